// File: rtl/interleaved_fifo_drain_scheduler.sv
// Round-robin burst scheduler draining NUM_CH valid/ready FIFO channels into one registered stream.
// Optional build macro SCHED_CH0_PRIO_EN: channel 0 wins every IDLE arbitration when it has data.
module interleaved_fifo_drain_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    input  logic [NUM_CH-1:0]              ch_valid,
    output logic [NUM_CH-1:0]              ch_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic                           busy
);
    localparam int GW = $clog2(NUM_CH);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [0:0]    IDLE  = 1'b0;
    localparam logic [0:0]    BURST = 1'b1;
    localparam logic [GW:0]   NCH   = (GW+1)'(NUM_CH);
    localparam logic [GW-1:0] LAST  = GW'(NUM_CH - 1);
    localparam logic [BW-1:0] BLAST = BW'(BURST_LEN - 1);

    logic [0:0]            state;
    logic [GW-1:0]         rr_ptr;
    logic [BW-1:0]         beat_cnt;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [2*NUM_CH-1:0]   rot;
    logic [GW-1:0]         off;
    logic [GW:0]           sum;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         g_next;
    logic                  in_burst;
    logic                  pop_ok;
    logic                  xfer;
    logic                  dry;
    logic                  last_beat;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (GW'(i) == grant_id) begin
                sel_valid = ch_valid[i];
                sel_data  = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit is the next winner.
    always_comb begin
        rot = {ch_valid, ch_valid} >> rr_ptr;
        off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) off = GW'(k);
        end
        sum  = {1'b0, rr_ptr} + {1'b0, off};
        pick = (sum >= NCH) ? GW'(sum - NCH) : GW'(sum);
    end

`ifdef SCHED_CH0_PRIO_EN
    assign winner = ch_valid[0] ? '0 : pick;
`else
    assign winner = pick;
`endif

    assign g_next    = (grant_id == LAST) ? '0 : grant_id + 1'b1;
    assign in_burst  = (state == BURST);
    assign busy      = in_burst;
    assign pop_ok    = !out_valid || out_ready;
    assign xfer      = in_burst && sel_valid && pop_ok;
    assign dry       = in_burst && pop_ok && !sel_valid;
    assign last_beat = xfer && (beat_cnt == BLAST);

    always_comb begin
        ch_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_burst && GW'(i) == grant_id) ch_ready[i] = pop_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (state == IDLE) begin
                if (|ch_valid) begin
                    grant_id <= winner;
                    beat_cnt <= '0;
                    state    <= BURST;
                end
            end else begin
                // A stalled output keeps pop_ok low, so neither exit nor count fires.
                if (last_beat || dry) begin
                    state  <= IDLE;
                    rr_ptr <= g_next;
                end else if (xfer) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (xfer) begin
                out_data  <= sel_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_interleaved_fifo_drain_scheduler.sv
// Directed bench for interleaved_fifo_drain_scheduler: vector table plus multi-cycle sequences.
module tb_interleaved_fifo_drain_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic [3:0]  ch_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    interleaved_fifo_drain_scheduler #(.NUM_CH(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst(rst), .clear(clear), .ch_data(ch_data), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic        e_busy;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rr;
    } vec_t;

`ifdef SCHED_CH0_PRIO_EN
    localparam logic [1:0] PRIO_GNT = 2'd0;
`else
    localparam logic [1:0] PRIO_GNT = 2'd3;
`endif

    // Simple FIFO models: each enabled channel always has a beat {ch, count}.
    logic [3:0] en;
    int         cnt [4];
    logic [7:0] seen [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        ch_valid = en;
        for (int i = 0; i < 4; i++) ch_data[i*8 +: 8] = {4'(i), 4'(cnt[i])};
    endtask

    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        if (out_valid && out_ready) seen.push_back(out_data);
        hs = ch_ready & ch_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear = 1'b0;
        out_ready = 1'b1;
        en = 4'b0000;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        seen.delete();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t tbl [6];
        tbl[0] = '{4'b0100, 32'h00A1_0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2, 2'd0};
        tbl[1] = '{4'b0100, 32'h00A1_0000, 1'b1, 4'b0100, 1'b1, 8'hA1, 1'b1, 2'd2, 2'd0};
        tbl[2] = '{4'b0100, 32'h00A2_0000, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b1, 2'd2, 2'd0};
        tbl[3] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 1'b0, 8'hA2, 1'b0, 2'd2, 2'd3};
        tbl[4] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hA2, 1'b0, 2'd2, 2'd3};
        tbl[5] = '{4'b1001, 32'hD300_00C0, 1'b1, 4'b0000, 1'b0, 8'hA2, 1'b1, PRIO_GNT, 2'd3};

        // Reset state
        rst = 1'b1; clear = 1'b0; out_ready = 1'b1; en = 4'b0; ch_valid = 4'b0; ch_data = '0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ch_ready", 32'(ch_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);

        // Run-dry on ch2, idle hold, then ch0/ch3 arbitration with rr_ptr=3
        do_reset();
        for (int r = 0; r < 6; r++) begin
            ch_valid = tbl[r].v; ch_data = tbl[r].d; out_ready = tbl[r].rdy;
            #2;
            chk($sformatf("tbl%0d_ch_ready", r), 32'(ch_ready), 32'(tbl[r].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].e_vld));
            chk($sformatf("tbl%0d_out_data", r), 32'(out_data), 32'(tbl[r].e_dat));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
            chk($sformatf("tbl%0d_grant", r), 32'(grant_id), 32'(tbl[r].e_gnt));
            chk($sformatf("tbl%0d_rr_ptr", r), 32'(dut.rr_ptr), 32'(tbl[r].e_rr));
        end

        // Fairness: all channels busy, grant order 0,1,2,3,0 with one bubble per grant
        do_reset();
        en = 4'b1111;
        drive();
        begin
            logic [7:0] beats [$];
            for (int t = 1; t <= 25; t++) begin
                tick();
                chk($sformatf("fair_vld_t%0d", t), 32'(out_valid), 32'((t % 5) != 1));
                if (t % 5 == 1) chk($sformatf("fair_grant_t%0d", t), 32'(grant_id), 32'((t / 5) % 4));
                if (out_valid) beats.push_back(out_data);
            end
            chk("fair_beat_count", 32'(beats.size()), 32'd20);
            for (int k = 0; k < beats.size() && k < 20; k++)
                chk($sformatf("fair_beat%0d", k), 32'(beats[k]),
                    32'({4'((k / 4) % 4), 4'((k / 16) * 4 + k % 4)}));
        end

        // Async reset mid-burst with a held output beat
        tick();
        tick();
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        chk("mid_vld_before_rst", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ch_ready", 32'(ch_ready), 32'd0);
        #1 rst = 1'b0;

        // Backpressure on ch1 after two beats
        do_reset();
        en = 4'b0010;
        drive();
        tick(); tick(); tick();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("bp%0d_ch_ready", s), 32'(ch_ready), 32'd0);
            chk($sformatf("bp%0d_out_data", s), 32'(out_data), 32'h11);
            chk($sformatf("bp%0d_beat_cnt", s), 32'(dut.beat_cnt), 32'd2);
            tick();
        end
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) tick();
        chk("bp_seen_count_ge4", 32'(seen.size() >= 4), 32'd1);
        for (int k = 0; k < seen.size(); k++)
            chk($sformatf("bp_seen%0d", k), 32'(seen[k]), 32'(8'h10 + k));

        // Clear during ch1 beat 2
        do_reset();
        en = 4'b0010;
        drive();
        tick(); tick(); tick();
        chk("clr_pre_busy", 32'(busy), 32'd1);
        chk("clr_pre_grant", 32'(grant_id), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        chk("clr_grant", 32'(grant_id), 32'd0);
        chk("clr_ch_ready", 32'(ch_ready), 32'd0);
        tick();
        chk("clr_regrant", 32'(grant_id), 32'd1);
        chk("clr_regrant_busy", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
